// File: rtl/game_stage_sequencer_pkg.sv
// Shared definitions for the game stage sequencer and the game-manager ROM reader:
// FSM encoding, stage record field widths and the end-of-table marker.
package game_stage_sequencer_pkg;

    localparam int STAGE_W   = 8;
    localparam int AMOUNT_W  = 10;
    localparam int GRAVITY_W = 3;
    localparam int COORD_W   = 10;
    localparam int WAIT_W    = 8;

    localparam logic [STAGE_W-1:0] END_STAGE_ID = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ACK   = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    // Live stage descriptor; wait_time is consumed by the timer and kept apart.
    typedef struct packed {
        logic [STAGE_W-1:0]   stage;
        logic [AMOUNT_W-1:0]  attack_amount;
        logic [AMOUNT_W-1:0]  platform_amount;
        logic [GRAVITY_W-1:0] gravity_direction;
        logic [COORD_W-1:0]   x1;
        logic [COORD_W-1:0]   y1;
        logic [COORD_W-1:0]   x2;
        logic [COORD_W-1:0]   y2;
    } stage_desc_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_stage_sequencer_stage_wait_timer.sv
// Stage wait timer: counts frame ticks into wait units and flags the tick that
// finishes the last unit. A zero unit count never expires.
module stage_wait_timer
    import game_stage_sequencer_pkg::*;
#(
    parameter int TICKS_PER_UNIT = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_units,
    input  logic              run,
    input  logic              frame_tick,
    input  logic              pause,
    output logic              expired
);
    localparam int                TICK_W    = cnt_width(TICKS_PER_UNIT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);

    logic [TICK_W-1:0] tick_cnt_r, tick_cnt_s;
    logic [WAIT_W-1:0] unit_cnt_r, unit_cnt_s;
    logic              step_s, wrap_s;

    // Counter next-state and expiry decode
    always_comb begin
        step_s     = run && frame_tick && !pause;
        wrap_s     = step_s && (tick_cnt_r == TICK_LAST);
        tick_cnt_s = tick_cnt_r;
        unit_cnt_s = unit_cnt_r;
        if (load) begin
            tick_cnt_s = '0;
            unit_cnt_s = load_units;
        end else if (wrap_s) begin
            tick_cnt_s = '0;
            if (unit_cnt_r != '0) begin
                unit_cnt_s = unit_cnt_r - WAIT_W'(1);
            end else begin
                unit_cnt_s = unit_cnt_r;
            end
        end else if (step_s) begin
            tick_cnt_s = tick_cnt_r + TICK_W'(1);
        end else begin
            tick_cnt_s = tick_cnt_r;
        end
        expired = wrap_s && (unit_cnt_r == WAIT_W'(1));
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= '0;
            unit_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_s;
            unit_cnt_r <= unit_cnt_s;
        end
    end

endmodule

// File: rtl/game_stage_sequencer.sv
// Game stage sequencer: fetches stage records through the ROM reader, holds the
// live stage descriptor and advances on wait timeout or early clear.
module game_stage_sequencer
    import game_stage_sequencer_pkg::*;
#(
    parameter int                 ADDR_WIDTH     = 8,
    parameter int                 TICKS_PER_UNIT = 60,
    parameter int                 ACK_TIMEOUT    = 15,
    parameter logic [STAGE_W-1:0] END_STAGE      = END_STAGE_ID
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  frame_tick,
    input  logic                  pause,
    input  logic                  stage_clear,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  sync_game_manager,
    input  logic                  update_game_manager,
    input  logic [STAGE_W-1:0]    rom_stage,
    input  logic [AMOUNT_W-1:0]   rom_attack_amount,
    input  logic [AMOUNT_W-1:0]   rom_platform_amount,
    input  logic [GRAVITY_W-1:0]  rom_gravity_direction,
    input  logic [COORD_W-1:0]    rom_x1,
    input  logic [COORD_W-1:0]    rom_y1,
    input  logic [COORD_W-1:0]    rom_x2,
    input  logic [COORD_W-1:0]    rom_y2,
    input  logic [WAIT_W-1:0]     rom_wait_time,
    output logic [STAGE_W-1:0]    cur_stage,
    output logic [AMOUNT_W-1:0]   cur_attack_amount,
    output logic [AMOUNT_W-1:0]   cur_platform_amount,
    output logic [GRAVITY_W-1:0]  cur_gravity_direction,
    output logic [COORD_W-1:0]    cur_x1,
    output logic [COORD_W-1:0]    cur_y1,
    output logic [COORD_W-1:0]    cur_x2,
    output logic [COORD_W-1:0]    cur_y2,
    output logic                  stage_start,
    output logic                  stage_active,
    output logic                  sequence_done,
    output logic                  rom_error
);
    localparam int               ACK_W    = cnt_width(ACK_TIMEOUT);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    seq_state_t            state_r, state_s;
    stage_desc_t           shadow_r, shadow_s, cur_r, cur_s;
    logic [WAIT_W-1:0]     shadow_wait_r, shadow_wait_s;
    logic [ADDR_WIDTH-1:0] rom_addr_r, rom_addr_s;
    logic [ACK_W-1:0]      ack_cnt_r, ack_cnt_s;
    logic                  rom_error_r, rom_error_s;
    logic                  stage_start_r, stage_start_s;
    logic                  sync_r, sync_s, active_r, active_s, done_r, done_s;
    logic                  run_s, load_s, expired_s;
    logic                  is_end_s, last_addr_s, ack_expire_s, advance_s;

    assign run_s = (state_r == ST_RUN);

    stage_wait_timer #(
        .TICKS_PER_UNIT(TICKS_PER_UNIT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .load_units(shadow_wait_r),
        .run       (run_s),
        .frame_tick(frame_tick),
        .pause     (pause),
        .expired   (expired_s)
    );

    // Condition decode shared by next-state and output logic
    always_comb begin
        is_end_s     = (shadow_r.stage == END_STAGE);
        last_addr_s  = (rom_addr_r == {ADDR_WIDTH{1'b1}});
        ack_expire_s = (state_r == ST_ACK) && !update_game_manager && (ack_cnt_r == ACK_LAST);
        advance_s    = run_s && (stage_clear || expired_s);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_s = ST_FETCH;
                else       state_s = state_r;
            end
            ST_FETCH: state_s = ST_ACK;
            ST_ACK: begin
                if (update_game_manager) state_s = ST_CHECK;
                else if (ack_expire_s)   state_s = ST_DONE;
                else                     state_s = ST_ACK;
            end
            ST_CHECK: begin
                if (is_end_s) state_s = ST_DONE;
                else          state_s = ST_RUN;
            end
            ST_RUN: begin
                if (advance_s) state_s = last_addr_s ? ST_DONE : ST_FETCH;
                else           state_s = ST_RUN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and record datapath
    always_comb begin
        rom_addr_s    = rom_addr_r;
        ack_cnt_s     = ack_cnt_r;
        rom_error_s   = rom_error_r;
        shadow_s      = shadow_r;
        shadow_wait_s = shadow_wait_r;
        cur_s         = cur_r;
        stage_start_s = 1'b0;
        load_s        = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rom_addr_s  = '0;
                    rom_error_s = 1'b0;
                end else begin
                    rom_addr_s  = rom_addr_r;
                end
            end
            ST_FETCH: ack_cnt_s = '0;
            ST_ACK: begin
                if (update_game_manager) begin
                    shadow_s = '{stage: rom_stage, attack_amount: rom_attack_amount,
                                 platform_amount: rom_platform_amount,
                                 gravity_direction: rom_gravity_direction,
                                 x1: rom_x1, y1: rom_y1, x2: rom_x2, y2: rom_y2};
                    shadow_wait_s = rom_wait_time;
                end else if (ack_expire_s) begin
                    rom_error_s = 1'b1;
                end else begin
                    ack_cnt_s = ack_cnt_r + ACK_W'(1);
                end
            end
            ST_CHECK: begin
                if (!is_end_s) begin
                    cur_s         = shadow_r;
                    stage_start_s = 1'b1;
                    load_s        = 1'b1;
                end else begin
                    cur_s = cur_r;
                end
            end
            ST_RUN: begin
                if (advance_s && !last_addr_s) rom_addr_s = rom_addr_r + ADDR_WIDTH'(1);
                else                           rom_addr_s = rom_addr_r;
            end
            default: rom_addr_s = rom_addr_r;
        endcase
        sync_s   = (state_s != ST_FETCH);
        active_s = (state_s == ST_RUN);
        done_s   = (state_s == ST_DONE);
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_r    <= '0;
            ack_cnt_r     <= '0;
            rom_error_r   <= 1'b0;
            shadow_r      <= '0;
            shadow_wait_r <= '0;
            cur_r         <= '0;
            stage_start_r <= 1'b0;
            sync_r        <= 1'b1;
            active_r      <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            rom_addr_r    <= rom_addr_s;
            ack_cnt_r     <= ack_cnt_s;
            rom_error_r   <= rom_error_s;
            shadow_r      <= shadow_s;
            shadow_wait_r <= shadow_wait_s;
            cur_r         <= cur_s;
            stage_start_r <= stage_start_s;
            sync_r        <= sync_s;
            active_r      <= active_s;
            done_r        <= done_s;
        end
    end

    assign rom_addr              = rom_addr_r;
    assign sync_game_manager     = sync_r;
    assign cur_stage             = cur_r.stage;
    assign cur_attack_amount     = cur_r.attack_amount;
    assign cur_platform_amount   = cur_r.platform_amount;
    assign cur_gravity_direction = cur_r.gravity_direction;
    assign cur_x1                = cur_r.x1;
    assign cur_y1                = cur_r.y1;
    assign cur_x2                = cur_r.x2;
    assign cur_y2                = cur_r.y2;
    assign stage_start           = stage_start_r;
    assign stage_active          = active_r;
    assign sequence_done         = done_r;
    assign rom_error             = rom_error_r;

endmodule
